fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the MIPS pipeline. Holds the PC, drives the instruction-memory
//  address, and registers InstrD/PCPlus4D for the decode stage (Control_Unit + register file).
//  Honours hazard-unit stalls, decode-resolved branch redirects, debug freeze/single-step and a halt opcode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  HALT_INSTR  32'hFFFF_FFFF  instruction word that stops fetch
//  CNT_WIDTH   32             width of the executed-cycle counter
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  enable_i       in   1   1 = free-run; 0 = frozen (debug unit owns the pipeline)
//  step_i         in   1   1-cycle pulse while enable_i=0: advance exactly one cycle
//  StallF         in   1   hazard unit: hold PC
//  StallD         in   1   hazard unit: hold IF/ID
//  PCSrcD         in   1   branch taken, resolved in decode
//  PCBranchD      in   32  branch target from decode
//  imem_addr      out  32  = PC (combinational from PC register); memory returns word same cycle
//  imem_rdata     in   32  instruction word at imem_addr
//  InstrD         out  32  IF/ID instruction; 0 (sll $0,$0,0 = NOP) when invalid
//  PCPlus4D       out  32  IF/ID PC+4
//  ValidD         out  1   IF/ID holds a real instruction
//  halted_o       out  1   HALTED state
//  cycle_count_o  out  CNT_WIDTH  number of advancing cycles since reset
// BEHAVIOUR
//  Reset (async assert, sync release): PC=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, halted_o=0,
//   cycle_count_o=0, state=IDLE.
//  adv = enable_i | step_i. When adv=0, all registers hold (including the counter); step_i is ignored
//   when enable_i=1.
//  FSM:
//   IDLE: first adv cycle after reset moves to RUN; no fetch is captured (ValidD stays 0).
//   RUN: normal fetch.
//   HALTED: terminal until rst_n is asserted.
//  RUN, per adv cycle, in priority order:
//   1. StallD=1: IF/ID holds. PC holds if StallF=1. PCSrcD is ignored.
//   2. PCSrcD=1: PC<=PCBranchD; IF/ID flushed (InstrD=0, ValidD=0, PCPlus4D=0). A halt word fetched
//      in this cycle is discarded; no transition.
//   3. StallF=1 (StallD=0): PC holds; IF/ID loads a bubble.
//   4. Otherwise:
//      - InstrD<=imem_rdata, PCPlus4D<=PC+4, ValidD<=1.
//      - If imem_rdata==HALT_INSTR: PC holds, state<=HALTED, InstrD<=0, ValidD<=0
//        (the halt itself is not issued).
//      - Else PC<=PC+4.
//  HALTED: PC frozen. Each adv cycle loads a bubble into IF/ID so the downstream stages drain.
//   Inputs are ignored.
//  cycle_count_o increments on every adv cycle in RUN, including stall and flush cycles.
//   Frozen in IDLE/HALTED. Wraps modulo 2^CNT_WIDTH.
//  Arithmetic: PC+4 is 32-bit, wraps 32'hFFFF_FFFC -> 0. PCBranchD is taken verbatim; bits [1:0] are
//   not checked.
//  Latency: an instruction is on imem_rdata in cycle n and on InstrD in cycle n+1.
//   A redirect asserted in cycle n puts the target on imem_addr in cycle n+1.
//  Reset asserted mid-operation: immediate return to reset values. Any in-flight IF/ID contents are lost.
// STRUCTURE
//  Shared package mips_pkg: NOP_INSTR=32'h0, RESET_PC, HALT_INSTR, and the fetch FSM state encoding
//   (IDLE=2'd0, RUN=2'd1, HALTED=2'd2).
//  One sub-module: if_id_reg. A 65-bit register (Instr, PCPlus4, Valid) with en/clr ports and clr
//   dominant; reused by later stage registers.
//  PC register, next-PC mux, FSM and counter live in fetch_stage.
// TESTING
//  1. Reset, then enable_i=1, imem word=addr+1: imem_addr 0,4,8...; InstrD=1 one cycle after addr 0
//     is presented; PCPlus4D=4.
//  2. StallF=StallD=1 for 3 cycles at PC=8: PC stays 8, InstrD holds, cycle_count still +3.
//     Release: fetch resumes at 8.
//  3. PCSrcD=1, PCBranchD=32'h40 with StallD=0: next imem_addr=0x40, InstrD=0, ValidD=0.
//     Repeat with StallD=1: PC and IF/ID unchanged.
//  4. Halt word at 0x10: halted_o=1 next cycle, PC stays 0x10, ValidD=0 afterwards.
//     Halt word in the same cycle as PCSrcD=1: no halt.
//  5. enable_i=0 with no step: all outputs frozen for 5 cycles. Three step_i pulses: PC advances
//     exactly 12, counter +3.
//  6. Assert rst_n low mid-run at PC=0x20 with ValidD=1: all outputs at reset values immediately,
//     without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Fetch FSM encoding and the IF/ID bundle live here.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc_plus4: 32'h0000_0000,
        valid:    1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// 65-bit inter-stage register (instr, pc+4, valid).
// clr wins over en and loads a bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IF_ID_BUBBLE;
        end else if (clr) begin
            q <= IF_ID_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, next-PC selection, fetch FSM,
// executed-cycle counter and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] HALT_INSTR = mips_pkg::HALT_INSTR,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 step_i,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 PCSrcD,
    input  logic [31:0]          PCBranchD,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o
);

    import mips_pkg::*;

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [31:0]          pc_q;
    logic [31:0]          pc_d;
    logic [31:0]          pc_plus4;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cnt_inc;
    logic                 adv;
    logic                 ifid_en;
    logic                 ifid_clr;
    if_id_t               ifid_d;
    if_id_t               ifid_q;

    assign adv      = enable_i | step_i;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_en  = 1'b0;
        ifid_clr = 1'b0;
        cnt_inc  = 1'b0;
        ifid_d   = '{
            instr:    imem_rdata,
            pc_plus4: pc_plus4,
            valid:    1'b1
        };
        if (adv) begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    cnt_inc = 1'b1;
                    priority case (1'b1)
                        // StallD without StallF still lets the PC move on
                        StallD: begin
                            if (!StallF) begin
                                pc_d = pc_plus4;
                            end
                        end
                        PCSrcD: begin
                            pc_d     = PCBranchD;
                            ifid_clr = 1'b1;
                        end
                        StallF: ifid_clr = 1'b1;
                        (imem_rdata == HALT_INSTR): begin
                            state_d      = HALTED;
                            ifid_en      = 1'b1;
                            ifid_d.instr = NOP_INSTR;
                            ifid_d.valid = 1'b0;
                        end
                        default: begin
                            pc_d    = pc_plus4;
                            ifid_en = 1'b1;
                        end
                    endcase
                end
                HALTED: ifid_clr = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr     = pc_q;
    assign InstrD        = ifid_q.instr;
    assign PCPlus4D      = ifid_q.pc_plus4;
    assign ValidD        = ifid_q.valid;
    assign halted_o      = (state_q == HALTED);
    assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table plus
// scoreboard queue, and a hand-written async reset sequence.
module tb_fetch_stage;

    localparam logic [31:0] NH = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic        step_i;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        halted_o;
    logic [31:0] cycle_count_o;
    logic [31:0] halt_addr;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        en;
        logic        step;
        logic        sf;
        logic        sd;
        logic        ps;
        logic [31:0] bt;
        logic [31:0] ha;
        logic [31:0] ea;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        ev;
        logic        eh;
        logic [31:0] ec;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] ea;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        ev;
        logic        eh;
        logic [31:0] ec;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .step_i        (step_i),
        .StallF        (StallF),
        .StallD        (StallD),
        .PCSrcD        (PCSrcD),
        .PCBranchD     (PCBranchD),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .InstrD        (InstrD),
        .PCPlus4D      (PCPlus4D),
        .ValidD        (ValidD),
        .halted_o      (halted_o),
        .cycle_count_o (cycle_count_o)
    );

    // Instruction memory: word = addr+1, or the halt word at halt_addr
    always_comb begin
        imem_rdata = imem_addr + 32'd1;
        if (imem_addr == halt_addr) begin
            imem_rdata = 32'hFFFF_FFFF;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=%h req=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " addr"}, imem_addr, e.ea);
        chk({tag, " instr"}, InstrD, e.ei);
        chk({tag, " pc4"}, PCPlus4D, e.ep);
        chk({tag, " valid"}, 32'(ValidD), 32'(e.ev));
        chk({tag, " halted"}, 32'(halted_o), 32'(e.eh));
        chk({tag, " cnt"}, cycle_count_o, e.ec);
    endtask

    function automatic vec_t mk(
        input logic en, input logic step, input logic sf,
        input logic sd, input logic ps, input logic [31:0] bt,
        input logic [31:0] ha, input logic [31:0] ea,
        input logic [31:0] ei, input logic [31:0] ep,
        input logic ev, input logic eh, input logic [31:0] ec);
        vec_t v;
        v.en = en; v.step = step; v.sf = sf; v.sd = sd;
        v.ps = ps; v.bt = bt; v.ha = ha; v.ea = ea;
        v.ei = ei; v.ep = ep; v.ev = ev; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    task automatic drive(input logic en, input logic step,
                         input logic sf, input logic sd,
                         input logic ps, input logic [31:0] bt);
        enable_i  = en;
        step_i    = step;
        StallF    = sf;
        StallD    = sd;
        PCSrcD    = ps;
        PCBranchD = bt;
    endtask

    initial begin
        exp_t e;
        exp_t r;
        n_cmp = 0;
        n_err = 0;
        halt_addr = NH;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // fill-in: fetch, stalls, flushes, freeze/step, wrap, halt
        tbl.push_back(mk(1,0,0,0,0,0,NH, 32'h00,32'h00,32'h00,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,NH, 32'h04,32'h01,32'h04,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,NH, 32'h08,32'h05,32'h08,1,0,2));
        tbl.push_back(mk(1,0,1,1,0,0,NH, 32'h08,32'h05,32'h08,1,0,3));
        tbl.push_back(mk(1,0,1,1,0,0,NH, 32'h08,32'h05,32'h08,1,0,4));
        tbl.push_back(mk(1,0,1,1,0,0,NH, 32'h08,32'h05,32'h08,1,0,5));
        tbl.push_back(mk(1,0,0,0,0,0,NH, 32'h0C,32'h09,32'h0C,1,0,6));
        tbl.push_back(mk(1,0,0,0,1,32'h40,NH, 32'h40,0,0,0,0,7));
        tbl.push_back(mk(1,0,0,0,0,0,NH, 32'h44,32'h41,32'h44,1,0,8));
        tbl.push_back(mk(1,0,1,1,1,32'h80,NH, 32'h44,32'h41,32'h44,1,0,9));
        tbl.push_back(mk(1,0,1,0,0,0,NH, 32'h44,0,0,0,0,10));
        tbl.push_back(mk(1,0,0,1,0,0,NH, 32'h48,0,0,0,0,11));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0,0,i[0],0,1,32'h80,NH,
                             32'h48,0,0,0,0,11));
        end
        tbl.push_back(mk(0,1,0,0,0,0,NH, 32'h4C,32'h49,32'h4C,1,0,12));
        tbl.push_back(mk(0,0,0,0,0,0,NH, 32'h4C,32'h49,32'h4C,1,0,12));
        tbl.push_back(mk(0,1,0,0,0,0,NH, 32'h50,32'h4D,32'h50,1,0,13));
        tbl.push_back(mk(0,0,0,0,0,0,NH, 32'h50,32'h4D,32'h50,1,0,13));
        tbl.push_back(mk(0,1,0,0,0,0,NH, 32'h54,32'h51,32'h54,1,0,14));
        tbl.push_back(mk(1,1,0,0,0,0,NH, 32'h58,32'h55,32'h58,1,0,15));
        tbl.push_back(mk(1,0,0,0,1,32'hFFFF_FFFC,NH,
                         32'hFFFF_FFFC,0,0,0,0,16));
        tbl.push_back(mk(1,0,0,0,0,0,NH, 0,32'hFFFF_FFFD,0,1,0,17));
        tbl.push_back(mk(1,0,0,0,1,32'h10,32'h00, 32'h10,0,0,0,0,18));
        tbl.push_back(mk(1,0,0,0,0,0,32'h10, 32'h10,0,32'h14,0,1,19));
        tbl.push_back(mk(1,0,0,0,1,32'h80,32'h10, 32'h10,0,0,0,1,19));
        tbl.push_back(mk(1,0,0,0,0,0,32'h10, 32'h10,0,0,0,1,19));
        tbl.push_back(mk(0,1,1,1,0,0,32'h10, 32'h10,0,0,0,1,19));

        @(posedge clk);
        #1;
        e = '{idx: -1, ea: 0, ei: 0, ep: 0, ev: 0, eh: 0, ec: 0};
        chk_all("reset", e);
        #2 rst_n = 1'b1;

        foreach (tbl[i]) begin
            halt_addr = tbl[i].ha;
            drive(tbl[i].en, tbl[i].step, tbl[i].sf,
                  tbl[i].sd, tbl[i].ps, tbl[i].bt);
            sb.push_back('{idx: i, ea: tbl[i].ea, ei: tbl[i].ei,
                           ep: tbl[i].ep, ev: tbl[i].ev,
                           eh: tbl[i].eh, ec: tbl[i].ec});
            @(posedge clk);
            #1;
            r = sb.pop_front();
            chk_all($sformatf("row%0d", r.idx), r);
        end

        // async reset mid-run at PC=0x20 with a valid IF/ID entry
        halt_addr = NH;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
        end
        #1;
        chk("prerst addr", imem_addr, 32'h20);
        chk("prerst valid", 32'(ValidD), 32'd1);
        chk("prerst instr", InstrD, 32'h1D);
        chk("prerst cnt", cycle_count_o, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        e = '{idx: -2, ea: 0, ei: 0, ep: 0, ev: 0, eh: 0, ec: 0};
        chk_all("asyncrst", e);
        #3 rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
